track_selector: RTL

Parametrised successor to the MP3 player's song-switch block. It holds the index of the current track and updates it from several sources:
- debounced prev/next buttons, with a configurable lock-out period;
- a direct-select port;
- an end-of-track pulse from the decoder.

---
 rtl/player_pkg.sv | 35 +++
 rtl/track_history_lifo.sv | 64 ++++++
 rtl/track_selector.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/player_pkg.sv
`default_nettype none
// ============================================================================
// Module   : player_pkg
// Purpose  : Shared types and constants for the track-selection logic.
//            - mode_t       : play mode encoding on the 2-bit mode port
//            - lock_state_t : button lock-out FSM states
//            - LFSR_SEED    : reset value of the shuffle LFSR
//            - lfsr_next()  : one step of the 16-bit Fibonacci LFSR
//                             (taps 16, 14, 13, 11)
// Revision : 1.0  initial release
// ============================================================================
package player_pkg;

    typedef enum logic [1:0] {
        MODE_SEQ      = 2'd0,
        MODE_REPEAT1  = 2'd1,
        MODE_SHUFFLE  = 2'd2,
        MODE_STOP_END = 2'd3
    } mode_t;

    typedef enum logic [0:0] {
        READY  = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Shift towards the MSB; the new bit is the XOR of taps 16,14,13,11
    // (bit positions 15,13,12,10).
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/track_history_lifo.sv
`default_nettype none
// ============================================================================
// Module   : track_history_lifo
// Purpose  : Small LIFO of previously played track indices. A push onto a
//            full stack silently drops the oldest entry.
// Ports    : clk, rst_n       clock, asynchronous active-low reset
//            i_push, i_din    push i_din on top
//            i_pop            drop the top entry (ignored when empty)
//            i_clear          empty the stack (highest priority)
//            o_top            current top-of-stack value
//            o_empty          stack holds no entries
// Revision : 1.0  initial release
// ============================================================================
module track_history_lifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

    // Entry 0 is the top; older entries sit at higher indices, so a push
    // shifts everything down and the oldest falls off the end.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_push) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
            if (r_count != c_FULL) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (i_pop && (r_count != '0)) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                r_mem[i] <= r_mem[i+1];
            end
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_top   = r_mem[0];
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/track_selector.sv
`default_nettype none
// ============================================================================
// Module   : track_selector
// Purpose  : Holds the current track index and updates it from direct
//            select, prev/next buttons (with lock-out / auto-repeat) and the
//            decoder end-of-track pulse, in one of four play modes.
// Ports    : clk, rst_n   clock, asynchronous active-low reset
//            prev, next   level-sensitive buttons
//            song_end     one-cycle end-of-track pulse
//            mode         0 SEQ, 1 REPEAT1, 2 SHUFFLE, 3 STOP_END
//            sel_valid    direct-select strobe, sel_idx = requested index
//            current      registered track index
//            changed      one-cycle pulse: track (re)started
//            stop         one-cycle pulse: playlist exhausted (STOP_END)
// Config   : TRACK_HISTORY_EN - when defined, prev walks back through a
//            4-entry history of previously played tracks.
// Revision : 1.0  initial release
// ============================================================================
module track_selector
    import player_pkg::*;
#(
    parameter  int SONG_NUM = 5,
    parameter  int LOCKOUT  = 400000,
    localparam int IDX_W    = $clog2(SONG_NUM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prev,
    input  logic             next,
    input  logic             song_end,
    input  logic [1:0]       mode,
    input  logic             sel_valid,
    input  logic [IDX_W-1:0] sel_idx,
    output logic [IDX_W-1:0] current,
    output logic             changed,
    output logic             stop
);

    localparam int CNT_W = $clog2(LOCKOUT + 1);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(LOCKOUT - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(SONG_NUM - 1);
    // SONG_NUM may not fit in IDX_W bits (e.g. SONG_NUM = 4), so range
    // checks are done one bit wider.
    localparam logic [IDX_W:0]   c_NUM_EXT  = (IDX_W+1)'(SONG_NUM);
    // Truncated copy is enough for the wrap subtraction: modulo-2^IDX_W
    // arithmetic still yields r - SONG_NUM when r >= SONG_NUM.
    localparam logic [IDX_W-1:0] c_NUM_LO   = IDX_W'(SONG_NUM);

    lock_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_lfsr;
    logic [IDX_W-1:0] r_current;
    logic             r_changed;
    logic             r_stop;

    mode_t            w_mode;
    logic [IDX_W-1:0] w_inc;
    logic [IDX_W-1:0] w_dec;
    logic [IDX_W-1:0] w_rnd;
    logic [IDX_W-1:0] w_rnd_wrapped;
    logic [IDX_W-1:0] w_shuffle;
    logic             w_sel_ok;
    logic             w_ready;
    logic             w_accept_btn;
    logic [IDX_W-1:0] w_nxt_current;
    logic             w_nxt_changed;
    logic             w_nxt_stop;

    assign w_mode   = mode_t'(mode);
    assign w_ready  = (r_state == READY);
    assign w_sel_ok = ({1'b0, sel_idx} < c_NUM_EXT);

    assign w_inc = (r_current == c_IDX_LAST) ? '0 : r_current + IDX_W'(1);
    assign w_dec = (r_current == '0) ? c_IDX_LAST : r_current - IDX_W'(1);

    // Shuffle never replays the current track: a collision falls through
    // to the next sequential index.
    assign w_rnd         = r_lfsr[IDX_W-1:0];
    assign w_rnd_wrapped = ({1'b0, w_rnd} >= c_NUM_EXT) ? (w_rnd - c_NUM_LO) : w_rnd;
    assign w_shuffle     = (w_rnd_wrapped == r_current) ? w_inc : w_rnd_wrapped;

`ifdef TRACK_HISTORY_EN
    logic             w_hist_push;
    logic             w_hist_pop;
    logic             w_hist_clear;
    logic [IDX_W-1:0] w_hist_top;
    logic             w_hist_empty;

    track_history_lifo #(
        .DEPTH (4),
        .WIDTH (IDX_W)
    ) u_history (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_hist_push),
        .i_pop   (w_hist_pop),
        .i_clear (w_hist_clear),
        .i_din   (r_current),
        .o_top   (w_hist_top),
        .o_empty (w_hist_empty)
    );
`endif

    // Single-winner event arbitration: sel_valid > prev > next > song_end.
    // An out-of-range select does not win, so lower events still apply.
    always_comb begin
        w_nxt_current = r_current;
        w_nxt_changed = 1'b0;
        w_nxt_stop    = 1'b0;
        w_accept_btn  = 1'b0;
`ifdef TRACK_HISTORY_EN
        w_hist_push   = 1'b0;
        w_hist_pop    = 1'b0;
        w_hist_clear  = 1'b0;
`endif
        if (sel_valid && w_sel_ok) begin
            w_nxt_current = sel_idx;
            w_nxt_changed = 1'b1;
`ifdef TRACK_HISTORY_EN
            w_hist_clear  = 1'b1;
`endif
        end else if (w_ready && prev) begin
            w_accept_btn  = 1'b1;
            w_nxt_changed = 1'b1;
            w_nxt_current = w_dec;
`ifdef TRACK_HISTORY_EN
            if (!w_hist_empty) begin
                w_nxt_current = w_hist_top;
                w_hist_pop    = 1'b1;
            end
`endif
        end else if (w_ready && next) begin
            w_accept_btn  = 1'b1;
            w_nxt_changed = 1'b1;
            w_nxt_current = (w_mode == MODE_SHUFFLE) ? w_shuffle : w_inc;
`ifdef TRACK_HISTORY_EN
            w_hist_push   = 1'b1;
`endif
        end else if (song_end) begin
            case (w_mode)
                MODE_SEQ: begin
                    w_nxt_current = w_inc;
                    w_nxt_changed = 1'b1;
`ifdef TRACK_HISTORY_EN
                    w_hist_push   = 1'b1;
`endif
                end
                MODE_REPEAT1: begin
                    w_nxt_changed = 1'b1;
                end
                MODE_SHUFFLE: begin
                    w_nxt_current = w_shuffle;
                    w_nxt_changed = 1'b1;
`ifdef TRACK_HISTORY_EN
                    w_hist_push   = 1'b1;
`endif
                end
                default: begin
                    if (r_current == c_IDX_LAST) begin
                        w_nxt_stop    = 1'b1;
                    end else begin
                        w_nxt_current = w_inc;
                        w_nxt_changed = 1'b1;
`ifdef TRACK_HISTORY_EN
                        w_hist_push   = 1'b1;
`endif
                    end
                end
            endcase
        end
    end

    // Lock-out FSM plus all registered outputs. The LFSR free-runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= READY;
            r_cnt     <= '0;
            r_lfsr    <= LFSR_SEED;
            r_current <= '0;
            r_changed <= 1'b0;
            r_stop    <= 1'b0;
        end else begin
            r_lfsr    <= lfsr_next(r_lfsr);
            r_current <= w_nxt_current;
            r_changed <= w_nxt_changed;
            r_stop    <= w_nxt_stop;
            case (r_state)
                READY: begin
                    if (w_accept_btn) begin
                        r_state <= LOCKED;
                        r_cnt   <= '0;
                    end
                end
                LOCKED: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= READY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= READY;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign current = r_current;
    assign changed = r_changed;
    assign stop    = r_stop;

endmodule
`default_nettype wire
